// File: rtl/sha256d_sequencer.sv
// Double SHA-256 sequencer for an 80-byte header: drives an external
// sha256_transform through three compression blocks and returns the final digest.
module sha256d_sequencer #(
  parameter int unsigned LATENCY = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [639:0] header_in,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out,
  output logic         tf_feedback,
  output logic [5:0]   tf_cnt,
  output logic [255:0] tf_state,
  output logic [511:0] tf_input,
  input  logic [255:0] tf_hash
);

  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [6:0] LAST = 7'(LATENCY - 1);

  typedef enum logic [2:0] {IDLE, BLK1, BLK2, BLK3, DONE} state_t;

  state_t         state;
  logic [639:0]   header_q;
  logic [255:0]   mid_q;
  logic [255:0]   inner_q;
  logic [6:0]     wait_cnt;
  logic           last;
  logic [511:0]   blk2_input;

  assign tf_feedback = 1'b0;
  assign tf_cnt      = '0;
  assign last        = (wait_cnt == LAST);

  // Tail of the header plus padding for an 80-byte (0x280-bit) message.
  assign blk2_input = {32'h00000280, 320'd0, 32'h80000000, header_q[639:512]};

  // Padded single block carrying a 32-byte (0x100-bit) inner digest.
  function automatic logic [511:0] final_block(input logic [255:0] digest);
    return {32'h00000100, 192'd0, 32'h80000000, digest};
  endfunction

  // On entry tf_* load straight from header_in/tf_hash; while a block is in
  // flight they reload from the latched copies, which hold the same value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      wait_cnt <= '0;
      hash_out <= '0;
      tf_state <= IV;
      tf_input <= '0;
      header_q <= '0;
      mid_q    <= '0;
      inner_q  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            header_q <= header_in;
            tf_state <= IV;
            tf_input <= header_in[511:0];
            wait_cnt <= '0;
            busy     <= 1'b1;
            state    <= BLK1;
          end
        end
        BLK1: begin
          if (last) begin
            mid_q    <= tf_hash;
            tf_state <= tf_hash;
            tf_input <= blk2_input;
            wait_cnt <= '0;
            state    <= BLK2;
          end else begin
            tf_input <= header_q[511:0];
            wait_cnt <= wait_cnt + 7'd1;
          end
        end
        BLK2: begin
          if (last) begin
            inner_q  <= tf_hash;
            tf_state <= IV;
            tf_input <= final_block(tf_hash);
            wait_cnt <= '0;
            state    <= BLK3;
          end else begin
            tf_state <= mid_q;
            tf_input <= blk2_input;
            wait_cnt <= wait_cnt + 7'd1;
          end
        end
        BLK3: begin
          if (last) begin
            hash_out <= tf_hash;
            done     <= 1'b1;
            busy     <= 1'b0;
            wait_cnt <= '0;
            state    <= DONE;
          end else begin
            tf_input <= final_block(inner_q);
            wait_cnt <= wait_cnt + 7'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256d_sequencer.sv
// Directed bench for sha256d_sequencer with a behavioural sha256_transform
// whose output is only valid after LATENCY cycles of stable inputs.
module tb_sha256d_sequencer;

  localparam int unsigned LATENCY = 65;
  localparam logic [255:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] GEN_DIGEST = {
    32'h00000000, 32'h68d61900, 32'he15a089c, 32'h931e8365,
    32'hae63f74f, 32'hc1a6a246, 32'hb6f1b372, 32'h6fe28c0a
  };

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [639:0] header_in;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;
  logic         tf_feedback;
  logic [5:0]   tf_cnt;
  logic [255:0] tf_state;
  logic [511:0] tf_input;
  logic [255:0] tf_hash;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  sha256d_sequencer #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .header_in(header_in),
    .busy(busy), .done(done), .hash_out(hash_out),
    .tf_feedback(tf_feedback), .tf_cnt(tf_cnt),
    .tf_state(tf_state), .tf_input(tf_input), .tf_hash(tf_hash)
  );

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
    for (int unsigned i = 0; i < 16; i++) w[i] = blk[32*i +: 32];
    for (int unsigned i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    a = st[31:0];    b = st[63:32];   c = st[95:64];   d = st[127:96];
    e = st[159:128]; f = st[191:160]; g = st[223:192]; h = st[255:224];
    for (int unsigned i = 0; i < 64; i++) begin
      s1 = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
      t1 = h + s1 + ((e & f) ^ (~e & g)) + K[i] + w[i];
      s0 = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
      t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + h, st[223:192] + g, st[191:160] + f, st[159:128] + e,
            st[127:96] + d, st[95:64] + c, st[63:32] + b, st[31:0] + a};
  endfunction

  function automatic logic [255:0] sha256d(input logic [639:0] hdr);
    logic [255:0] mid, inner;
    mid   = compress(IV, hdr[511:0]);
    inner = compress(mid, {32'h00000280, 320'd0, 32'h80000000, hdr[639:512]});
    return compress(IV, {32'h00000100, 192'd0, 32'h80000000, inner});
  endfunction

  function automatic logic [639:0] make_hdr(input logic [31:0] seed);
    logic [639:0] hh;
    for (int unsigned i = 0; i < 20; i++) hh[32*i +: 32] = seed ^ (32'(i) * 32'h9e3779b9);
    return hh;
  endfunction

  // Transform model: new inputs restart the pipeline; garbage until settled.
  logic [255:0] seen_state;
  logic [511:0] seen_input;
  logic [255:0] model_hash = '0;
  int unsigned  stable = 0;
  int unsigned  tie_errs = 0;
  logic [511:0] in_log [$];
  logic [255:0] st_log [$];

  always @(negedge clk) begin
    if (tf_state !== seen_state || tf_input !== seen_input) begin
      seen_state = tf_state;
      seen_input = tf_input;
      model_hash = compress(tf_state, tf_input);
      stable = 0;
      in_log.push_back(tf_input);
      st_log.push_back(tf_state);
    end else if (stable < 1000) begin
      stable++;
    end
    if (tf_feedback !== 1'b0 || tf_cnt !== 6'd0) tie_errs++;
  end

  assign tf_hash = (stable >= LATENCY - 1) ? model_hash : {8{32'hdeadbeef}};

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from the start request until done; optionally injects a
  // competing start with another header at edge poke_at.
  task automatic wait_done(input logic [255:0] prev, input int unsigned poke_at,
                           input logic [639:0] poke_hdr, output int unsigned n);
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (n == 1) begin
        start = 1'b0;
        check("busy_after_accept", busy, 1'b1);
        header_in = ~header_in;
      end
      if (n == poke_at) begin
        header_in = poke_hdr;
        start = 1'b1;
      end
      if (n == poke_at + 1) start = 1'b0;
      if (n == 100) check("hash_hold_mid_job", hash_out, prev);
      if (done === 1'b1) break;
    end
    if (n >= 400) check("done_timeout", done, 1'b1);
  endtask

  logic [639:0] gen_hdr, hdr_a, hdr_b, hdr_c;
  int unsigned  lat, dones;
  int unsigned  pulses [$];

  initial begin
    gen_hdr = '0;
    gen_hdr[31:0]    = 32'h01000000;
    gen_hdr[319:288] = 32'h3ba3edfd; gen_hdr[351:320] = 32'h7a7b12b2;
    gen_hdr[383:352] = 32'h7ac72c3e; gen_hdr[415:384] = 32'h67768f61;
    gen_hdr[447:416] = 32'h7fc81bc3; gen_hdr[479:448] = 32'h888a5132;
    gen_hdr[511:480] = 32'h3a9fb8aa; gen_hdr[543:512] = 32'h4b1e5e4a;
    gen_hdr[575:544] = 32'h29ab5f49; gen_hdr[607:576] = 32'hffff001d;
    gen_hdr[639:608] = 32'h1dac2b7c;
    hdr_a = make_hdr(32'h13572468);
    hdr_b = make_hdr(32'hcafef00d);
    hdr_c = make_hdr(32'h0badc0de);

    rst_n = 1'b0; start = 1'b0; header_in = '0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_hash_out", hash_out, '0);
    check("rst_tf_state", tf_state, IV);
    check("rst_tf_input", tf_input, '0);
    check("rst_tf_feedback", tf_feedback, 1'b0);
    check("rst_tf_cnt", tf_cnt, 6'd0);
    rst_n = 1'b1;
    tick();

    // Genesis block header
    in_log.delete(); st_log.delete();
    header_in = gen_hdr; start = 1'b1;
    wait_done('0, 0, '0, lat);
    check("gen_latency", lat, 196);
    check("gen_digest_const", hash_out, GEN_DIGEST);
    check("gen_h0", hash_out[31:0], 32'h6fe28c0a);
    check("gen_h7", hash_out[255:224], 32'h00000000);
    check("gen_digest_model", hash_out, sha256d(gen_hdr));
    check("gen_block_count", in_log.size(), 3);
    if (in_log.size() >= 3) begin
      check("blk1_state", st_log[0], IV);
      check("blk1_input", in_log[0], gen_hdr[511:0]);
      check("blk2_state", st_log[1], compress(IV, gen_hdr[511:0]));
      check("blk2_w0_3", in_log[1][127:0], gen_hdr[639:512]);
      check("blk2_w4", in_log[1][159:128], 32'h80000000);
      check("blk2_w5_14", in_log[1][479:160], '0);
      check("blk2_w15", in_log[1][511:480], 32'h00000280);
      check("blk3_state", st_log[2], IV);
      check("blk3_w8", in_log[2][287:256], 32'h80000000);
      check("blk3_w15", in_log[2][511:480], 32'h00000100);
    end
    tick();
    check("done_one_cycle", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);

    // All-zero header; previous digest must hold until this job's done
    in_log.delete(); st_log.delete();
    header_in = '0; start = 1'b1;
    wait_done(GEN_DIGEST, 0, '0, lat);
    check("zero_latency", lat, 196);
    check("zero_digest", hash_out, sha256d('0));
    check("zero_block_count", in_log.size(), 3);
    if (in_log.size() >= 3) check("zero_blk2_w15", in_log[1][511:480], 32'h00000280);
    tick();

    // Competing start during BLK2 must be ignored; start in DONE cycle too
    header_in = hdr_a; start = 1'b1;
    wait_done(sha256d('0), LATENCY + 10, hdr_b, lat);
    check("ignore_latency", lat, 196);
    check("ignore_digest", hash_out, sha256d(hdr_a));
    header_in = hdr_b; start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_ignored", busy, 1'b0);
    tick();
    check("still_idle", busy, 1'b0);

    // start held high: back-to-back jobs with one idle cycle between
    header_in = hdr_c; start = 1'b1;
    for (int unsigned n = 1; n <= 400; n++) begin
      tick();
      if (done === 1'b1) pulses.push_back(n);
    end
    start = 1'b0;
    check("held_pulse_count", pulses.size(), 2);
    if (pulses.size() >= 2) begin
      check("held_first_done", pulses[0], 196);
      check("held_spacing", pulses[1] - pulses[0], 197);
    end
    check("held_digest", hash_out, sha256d(hdr_c));
    lat = 0;
    while (lat < 300 && done !== 1'b1) begin
      tick();
      lat++;
    end
    check("third_job_done", done, 1'b1);
    check("third_job_digest", hash_out, sha256d(hdr_c));
    tick();

    // Asynchronous reset in the middle of BLK2
    header_in = hdr_b; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (LATENCY + 20) tick();
    check("busy_in_blk2", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_busy", busy, 1'b0);
    check("async_tf_input", tf_input, '0);
    check("async_tf_state", tf_state, IV);
    check("async_hash_out", hash_out, '0);
    rst_n = 1'b1;
    dones = 0;
    for (int unsigned n = 0; n < 3 * LATENCY + 20; n++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    check("aborted_no_done", dones, 0);
    check("aborted_idle", busy, 1'b0);
    in_log.delete(); st_log.delete();
    header_in = hdr_b; start = 1'b1;
    wait_done('0, 0, '0, lat);
    check("post_rst_latency", lat, 196);
    check("post_rst_digest", hash_out, sha256d(hdr_b));
    check("post_rst_block_count", in_log.size(), 3);
    check("tie_offs", tie_errs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
